booth_mul_iter: RTL and testbench
=================================

# booth_mul_iter

Iterative, parametrised radix-4 Booth multiplier for the EX stage. It implements RISC-V MUL/MULH/MULHSU/MULHU over XLEN-bit operands. Each cycle it consumes CHUNK multiplier bits: Booth partial products plus the fed-back sum/carry rows are reduced 2:1 in a Dadda-style carry-save tree. A final carry-propagate add resolves the result. Compared with the fixed 16-bit tree, it adds width/chunk parametrisation, signed/unsigned modes, a valid/ready handshake, flush and a zero early-out.

## Interface
- XLEN, 32: operand and result width.
- CHUNK, 16: multiplier bits retired per pass. Must be even, 4 ≤ CHUNK ≤ XLEN.
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- flush  in  1  kill the in-flight operation (pipeline flush).
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept.
- in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_a  in  XLEN  rs1 (multiplicand).
- in_b  in  XLEN  rs2 (multiplier).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_result  out  XLEN  low half (MUL) or high half (others) of the product.

## Operation
- Operand extension to XLEN+1 bits:
  - in_a is sign-extended for MUL/MULH/MULHSU and zero-extended for MULHU.
  - in_b is sign-extended for MUL/MULH and zero-extended for MULHSU/MULHU.
- Extended in_b is sign-padded to P·CHUNK bits, where P = ceil((XLEN+1)/CHUNK). P = 3 for the defaults.
- Pass k (0..P-1):
  - Recode bits [k·CHUNK-1 .. k·CHUNK+CHUNK-1] into CHUNK/2 radix-4 digits (−2..+2). Bit −1 of pass 0 is 0.
  - Each partial product is the inverted/shifted multiplicand plus its 2's-complement "add" bit.
  - Partial products are weighted by 2^(k·CHUNK+2i).
  - They are compressed together with the 2·XLEN+2-bit sum and carry accumulator rows back into sum/carry. Arithmetic is modulo 2^(2·XLEN+2).
- RESOLVE adds sum + carry and selects bits [XLEN-1:0] (MUL) or [2XLEN-1:XLEN] into the output register.
- Zero early-out: if in_a == 0 or in_b == 0 at accept, skip COMPRESS/RESOLVE, load out_result = 0 and go straight to DONE.
- FSM states and transitions:
  - IDLE: on accept (in_valid & in_ready & !flush), go to COMPRESS with pass counter = 0 and accumulators cleared. Early-out goes to DONE instead.
  - COMPRESS: increment the pass counter each cycle. Go to RESOLVE after pass P-1.
  - RESOLVE: go to DONE.
  - DONE: go to IDLE when out_ready.
- in_ready = (state == IDLE). There is no overlap between operations.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_result 0, pass counter 0, accumulators 0.
- Latency: out_valid rises P+2 edges after the accepting edge (5 for the defaults). With early-out it rises 1 edge after.
- out_valid and out_result are registered and held stable in DONE until out_ready. Handshake completes on out_valid & out_ready.
- Back-to-back: in_ready returns 1 in the cycle after the output handshake.
- flush (synchronous):
  - In any non-IDLE state, flush forces IDLE on the next edge and out_valid drops. No result is produced.
  - In IDLE, flush blocks acceptance in that cycle.
- rst overrides flush and all handshakes. rst mid-operation discards all state.
- Input operands are sampled only on the accepting edge. Later changes are ignored.

## Structure
- Package mul_pkg:
  - op encoding constants (MUL_OP_*);
  - FSM state enum (IDLE, COMPRESS, RESOLVE, DONE);
  - a function computing P from XLEN and CHUNK.
- Sub-module booth_csa_tree (combinational), parametrised by XLEN and CHUNK:
  - Booth recode of CHUNK bits;
  - generation of the CHUNK/2 partial products and add bits;
  - Dadda 3:2/4:2 reduction of CHUNK/2 + 2 rows to sum and carry.
- Top level holds the FSM, pass counter, operand/accumulator registers, final adder and handshake.

## Test plan
- MUL a=3, b=0xFFFFFFFB (−5) → out_result 0xFFFFFFF1. out_valid exactly 5 edges after accept.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU a=0xFFFFFFFF (−1), b=0xFFFFFFFF (unsigned) → 0xFFFFFFFF. Same operands with MUL → 0x00000001.
- Early-out: MULHU a=0, b=0x12345678 → 0 after 1 edge. in_ready stays low in the early-out DONE cycle.
- Backpressure: hold out_ready=0 for 10 cycles. out_valid and out_result stay stable and in_ready stays 0. The next op is accepted one cycle after the handshake.
- flush in cycle 2 of COMPRESS → IDLE next edge with no out_valid. rst mid-RESOLVE → all outputs at reset values next edge. Finish with a random sweep of all ops and XLEN ∈ {16, 32, 64}, CHUNK ∈ {4, 8, 16}, checked against a reference model.

Source files
------------

// File: rtl/booth_mul_iter_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier: op codes,
// FSM states and the elaboration-time sizing helpers.
package mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPRESS,
        ST_RESOLVE,
        ST_DONE
    } mul_state_e;

    // Number of passes: ceil((xlen+1)/chunk), since operands are extended by one bit.
    function automatic int calc_passes(input int xlen, input int chunk);
        return (xlen + chunk) / chunk;
    endfunction

    // Row count after a given number of 3:2 layers.
    function automatic int rows_at_level(input int nr, input int lvl);
        int n;
        n = nr;
        for (int l = 0; l < lvl; l++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    // Number of 3:2 layers needed to bring nr rows down to two.
    function automatic int num_levels(input int nr);
        int n;
        int l;
        n = nr;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + (n % 3);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/booth_mul_iter_if.sv
// Request/response bundle of the multiplier: operand handshake, result
// handshake and pipeline flush.
interface booth_mul_iter_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    modport master (
        output flush, in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/booth_mul_iter_csa_tree.sv
// One multiplier pass: radix-4 Booth recode of CHUNK bits, partial product
// generation and carry-save reduction together with the sum/carry rows.
// The 2's-complement add bits of all partial products sit at disjoint
// positions, so they are packed into a single extra row.
module booth_csa_tree
    import mul_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 16,
    parameter int PW    = 2
) (
    input  logic [XLEN:0]     mcand_i,
    input  logic [CHUNK:0]    bits_i,
    input  logic [PW-1:0]     pass_i,
    input  logic [2*XLEN+1:0] sum_i,
    input  logic [2*XLEN+1:0] carry_i,
    output logic [2*XLEN+1:0] sum_o,
    output logic [2*XLEN+1:0] carry_o
);
    localparam int W    = 2 * XLEN + 2;
    localparam int NPP  = CHUNK / 2;
    localparam int NR   = NPP + 3;
    localparam int NLVL = num_levels(NR);

    logic [W-1:0]     lvl [NLVL+1][NR];
    logic [CHUNK-1:0] add_spread;
    int               shamt;

    assign shamt = int'(pass_i) * CHUNK;

    genvar gi;
    genvar gl;
    generate
        for (gi = 0; gi < NPP; gi++) begin : g_pp
            logic [2:0]      trip;
            logic            neg;
            logic            one;
            logic            two;
            logic [XLEN+1:0] mag;
            logic [XLEN+1:0] pp;

            // bits_i[0] is multiplier bit k*CHUNK-1 of this pass
            assign trip = bits_i[2*gi +: 3];
            assign neg  = trip[2] & ~(trip[1] & trip[0]);
            assign one  = trip[1] ^ trip[0];
            assign two  = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
            assign mag  = one ? {mcand_i[XLEN], mcand_i} : (two ? {mcand_i, 1'b0} : '0);
            assign pp   = neg ? ~mag : mag;

            assign lvl[0][gi] = {{XLEN{pp[XLEN+1]}}, pp} << (2 * gi + shamt);
            assign add_spread[2*gi]   = neg;
            assign add_spread[2*gi+1] = 1'b0;
        end

        assign lvl[0][NPP]   = {{(W-CHUNK){1'b0}}, add_spread} << shamt;
        assign lvl[0][NPP+1] = sum_i;
        assign lvl[0][NPP+2] = carry_i;

        // Layered 3:2 compression; leftover rows of a layer pass straight through
        for (gl = 0; gl < NLVL; gl++) begin : g_lvl
            localparam int N    = rows_at_level(NR, gl);
            localparam int G    = N / 3;
            localparam int NOUT = 2 * G + (N % 3);
            for (gi = 0; gi < NR; gi++) begin : g_row
                if (gi < 2 * G) begin : g_csa
                    if (gi % 2 == 0) begin : g_s
                        assign lvl[gl+1][gi] = lvl[gl][3*(gi/2)] ^ lvl[gl][3*(gi/2)+1]
                                             ^ lvl[gl][3*(gi/2)+2];
                    end else begin : g_c
                        assign lvl[gl+1][gi] = ((lvl[gl][3*(gi/2)]   & lvl[gl][3*(gi/2)+1])
                                              | (lvl[gl][3*(gi/2)]   & lvl[gl][3*(gi/2)+2])
                                              | (lvl[gl][3*(gi/2)+1] & lvl[gl][3*(gi/2)+2])) << 1;
                    end
                end else if (gi < NOUT) begin : g_pass
                    assign lvl[gl+1][gi] = lvl[gl][gi + G];
                end else begin : g_zero
                    assign lvl[gl+1][gi] = '0;
                end
            end
        end
    endgenerate

    assign sum_o   = lvl[NLVL][0];
    assign carry_o = lvl[NLVL][1];

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier for RISC-V MUL/MULH/MULHSU/MULHU.
// Retires CHUNK multiplier bits per COMPRESS cycle into carry-save rows,
// then resolves them with one carry-propagate add.
module booth_mul_iter
    import mul_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 16
) (
    input  logic              clk,
    input  logic              rst,
    booth_mul_iter_if.slave   bus
);
    localparam int P  = calc_passes(XLEN, CHUNK);
    localparam int PB = P * CHUNK;
    localparam int W  = 2 * XLEN + 2;
    localparam int PW = $clog2(P + 1);

    mul_state_e      state_q,  state_d;
    logic [PW-1:0]   pass_q,   pass_d;
    logic [1:0]      op_q,     op_d;
    logic [XLEN:0]   a_q,      a_d;
    logic [PB:0]     b_q,      b_d;
    logic [W-1:0]    sum_q,    sum_d;
    logic [W-1:0]    carry_q,  carry_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [W-1:0]      tree_sum;
    logic [W-1:0]      tree_carry;
    logic [2*XLEN-1:0] total;
    logic              a_sign;
    logic              b_sign;

    booth_csa_tree #(
        .XLEN  (XLEN),
        .CHUNK (CHUNK),
        .PW    (PW)
    ) u_tree (
        .mcand_i (a_q),
        .bits_i  (b_q[CHUNK:0]),
        .pass_i  (pass_q),
        .sum_i   (sum_q),
        .carry_i (carry_q),
        .sum_o   (tree_sum),
        .carry_o (tree_carry)
    );

    // Only the product bits that can be selected are carried through the final add
    assign total  = sum_q[2*XLEN-1:0] + carry_q[2*XLEN-1:0];
    assign a_sign = (bus.in_op != MUL_OP_MULHU) & bus.in_a[XLEN-1];
    assign b_sign = ((bus.in_op == MUL_OP_MUL) | (bus.in_op == MUL_OP_MULH)) & bus.in_b[XLEN-1];

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_result = result_q;

    // Next-state and datapath updates; flush from any busy state returns to IDLE
    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        result_d = result_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    op_d    = bus.in_op;
                    a_d     = {a_sign, bus.in_a};
                    // bit 0 is the implicit zero below the multiplier LSB
                    b_d     = {{(PB-XLEN){b_sign}}, bus.in_b, 1'b0};
                    pass_d  = '0;
                    sum_d   = '0;
                    carry_d = '0;
                    if (bus.in_a == '0 || bus.in_b == '0) begin
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_COMPRESS;
                    end
                end
            end
            ST_COMPRESS: begin
                sum_d   = tree_sum;
                carry_d = tree_carry;
                b_d     = {{CHUNK{b_q[PB]}}, b_q[PB:CHUNK]};
                pass_d  = pass_q + PW'(1);
                if (pass_q == PW'(P - 1)) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                result_d = (op_q == MUL_OP_MUL) ? total[XLEN-1:0] : total[2*XLEN-1:XLEN];
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pass_q   <= '0;
            op_q     <= MUL_OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_booth_mul_iter.sv
// Bench for booth_mul_iter: directed handshake/flush/reset cases on the
// default 32/16 instance, then a random sweep over several XLEN/CHUNK
// instances compared against a wide-integer product model.
module tb_booth_mul_iter;
    import mul_pkg::*;

    localparam int NCFG = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    bit   sweep_go = 1'b0;

    always #5 clk = ~clk;

    booth_mul_iter_if #(.XLEN(32)) bus0 ();
    booth_mul_iter #(.XLEN(32), .CHUNK(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    function automatic int cfg_x(input int i);
        case (i)
            0: return 16;
            1: return 16;
            2: return 16;
            3: return 32;
            4: return 64;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_c(input int i);
        case (i)
            0: return 4;
            1: return 8;
            2: return 16;
            3: return 4;
            4: return 8;
            default: return 16;
        endcase
    endfunction

    // Reference: exact product of the extended operands, half selected by op
    function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input int xl);
        logic [127:0] m;
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] pr;
        m  = (128'd1 << xl) - 128'd1;
        ea = {64'd0, a} & m;
        eb = {64'd0, b} & m;
        if (op != MUL_OP_MULHU && a[xl-1]) ea = ea | ~m;
        if ((op == MUL_OP_MUL || op == MUL_OP_MULH) && b[xl-1]) eb = eb | ~m;
        pr = ea * eb;
        if (op == MUL_OP_MUL) return 64'(pr & m);
        return 64'((pr >> xl) & m);
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic mark_done();
        done_cnt++;
    endtask

    // Full transaction on the default instance; returns after the output handshake
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        bus0.out_ready = 1'b1;
        bus0.in_valid  = 1'b1;
        bus0.in_op     = op;
        bus0.in_a      = a;
        bus0.in_b      = b;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        bus0.in_a     = ~a;
        bus0.in_b     = b ^ 32'h5A5A_A5A5;
        lat = 1;
        while (bus0.out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, "_res"}, 64'(bus0.out_result), 64'(exp));
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_busy"}, 64'(bus0.in_ready), 64'd0);
        $display("txn %s op=%0d a=0x%08h b=0x%08h result=0x%08h lat=%0d",
                 tag, op, a, b, bus0.out_result, lat);
        @(posedge clk);
        #1;
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : g_cfg
            localparam int XL = cfg_x(gi);
            localparam int CK = cfg_c(gi);
            localparam int NP = calc_passes(XL, CK);

            booth_mul_iter_if #(.XLEN(XL)) sbus ();
            booth_mul_iter #(.XLEN(XL), .CHUNK(CK)) sdut (
                .clk (clk),
                .rst (rst),
                .bus (sbus)
            );

            initial begin : sweep
                logic [63:0] a;
                logic [63:0] b;
                logic [63:0] e;
                logic [63:0] mask;
                logic [1:0]  op;
                int          lat;
                sbus.flush     = 1'b0;
                sbus.in_valid  = 1'b0;
                sbus.out_ready = 1'b1;
                sbus.in_op     = 2'b00;
                sbus.in_a      = '0;
                sbus.in_b      = '0;
                while (!sweep_go) @(posedge clk);
                mask = (64'd1 << XL) - 64'd1;
                for (int n = 0; n < 40; n++) begin
                    a  = {$urandom, $urandom} & mask;
                    b  = {$urandom, $urandom} & mask;
                    op = 2'($urandom_range(0, 3));
                    if (n % 5 == 1) a = 64'd1 << (XL - 1);
                    if (n % 5 == 2) b = mask;
                    if (n % 7 == 3) a = mask;
                    if ($urandom_range(0, 11) == 0) a = '0;
                    if ($urandom_range(0, 11) == 0) b = '0;
                    @(negedge clk);
                    sbus.in_valid = 1'b1;
                    sbus.in_op    = op;
                    sbus.in_a     = a[XL-1:0];
                    sbus.in_b     = b[XL-1:0];
                    @(posedge clk);
                    #1;
                    sbus.in_valid = 1'b0;
                    sbus.in_a     = ~a[XL-1:0];
                    lat = 1;
                    while (sbus.out_valid !== 1'b1 && lat < 100) begin
                        @(posedge clk);
                        #1;
                        lat++;
                    end
                    e = ref_mul(op, a, b, XL);
                    check_val($sformatf("cfg%0d_res", gi), 64'(sbus.out_result), e);
                    check_val($sformatf("cfg%0d_lat", gi), 64'(lat),
                              (a == 0 || b == 0) ? 64'd1 : 64'(NP + 2));
                    $display("txn x%0d_c%0d op=%0d a=0x%0h b=0x%0h result=0x%0h lat=%0d",
                             XL, CK, op, a, b, sbus.out_result, lat);
                    @(posedge clk);
                    #1;
                end
                mark_done();
            end
        end
    endgenerate

    initial begin : main
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] exp;
        logic [1:0]  rop;
        int          seen;
        int          wait_cyc;
        bus0.flush     = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        bus0.in_op     = 2'b00;
        bus0.in_a      = '0;
        bus0.in_b      = '0;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_in_ready", 64'(bus0.in_ready), 64'd1);
        check_val("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        check_val("rst_out_result", 64'(bus0.out_result), 64'd0);

        run_op("mul_3xm5", MUL_OP_MUL, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 5);
        run_op("mulh_min", MUL_OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5);
        run_op("mulhu_max", MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        run_op("mulhsu_m1", MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        run_op("mul_m1", MUL_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5);
        run_op("early_out", MUL_OP_MULHU, 32'h0, 32'h1234_5678, 32'h0, 1);

        // Backpressure: result held in DONE while the consumer stalls
        @(negedge clk);
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        bus0.in_op     = MUL_OP_MUL;
        bus0.in_a      = 32'h0001_2345;
        bus0.in_b      = 32'h0006_789A;
        exp = 32'(ref_mul(MUL_OP_MUL, 64'h0001_2345, 64'h0006_789A, 32));
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        wait_cyc = 0;
        while (bus0.out_valid !== 1'b1 && wait_cyc < 60) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        for (int c = 0; c < 10; c++) begin
            check_val("bp_valid", 64'(bus0.out_valid), 64'd1);
            check_val("bp_result", 64'(bus0.out_result), 64'(exp));
            check_val("bp_in_ready", 64'(bus0.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        $display("txn backpressure result=0x%08h", bus0.out_result);
        @(negedge clk);
        bus0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_after_ready", 64'(bus0.in_ready), 64'd1);
        check_val("bp_after_valid", 64'(bus0.out_valid), 64'd0);
        run_op("bp_next", MUL_OP_MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 5);

        // Flush during the second COMPRESS cycle
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.in_op    = MUL_OP_MULH;
        bus0.in_a     = 32'h1357_9BDF;
        bus0.in_b     = 32'h2468_ACE0;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus0.flush = 1'b1;
        @(posedge clk);
        #1;
        bus0.flush = 1'b0;
        check_val("flush_in_ready", 64'(bus0.in_ready), 64'd1);
        check_val("flush_out_valid", 64'(bus0.out_valid), 64'd0);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus0.out_valid === 1'b1) seen++;
        end
        check_val("flush_no_result", 64'(seen), 64'd0);
        $display("txn flush_compress");

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        bus0.flush    = 1'b1;
        bus0.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus0.flush    = 1'b0;
        bus0.in_valid = 1'b0;
        check_val("flush_idle_block", 64'(bus0.in_ready), 64'd1);
        $display("txn flush_idle");

        // Reset during RESOLVE
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.in_op    = MUL_OP_MUL;
        bus0.in_a     = 32'd7;
        bus0.in_b     = 32'd9;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_val("resolve_busy", 64'(bus0.in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_mid_ready", 64'(bus0.in_ready), 64'd1);
        check_val("rst_mid_valid", 64'(bus0.out_valid), 64'd0);
        check_val("rst_mid_result", 64'(bus0.out_result), 64'd0);
        $display("txn reset_resolve");
        run_op("post_rst", MUL_OP_MUL, 32'd7, 32'd9, 32'd63, 5);

        // Random ops on the default instance
        for (int n = 0; n < 24; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 2'($urandom_range(0, 3));
            if (n % 8 == 5) ra = '0;
            if (n % 9 == 7) rb = '0;
            exp = 32'(ref_mul(rop, 64'(ra), 64'(rb), 32));
            run_op($sformatf("rnd%0d", n), rop, ra, rb, exp, (ra == 0 || rb == 0) ? 1 : 5);
        end

        sweep_go = 1'b1;
        wait_cyc = 0;
        while (done_cnt < NCFG && wait_cyc < 40000) begin
            @(posedge clk);
            wait_cyc++;
        end
        check_val("sweep_done", 64'(done_cnt), 64'(NCFG));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
